// File: rtl/hangman_guess_checker_if.sv
// Guess-checker bus: game control inputs and status outputs.
// Clock and reset stay as plain ports on the checker itself.
interface hangman_guess_checker_if #(
    parameter int unsigned WORD_LEN = 8
);
    logic                  init;
    logic                  check_guess;
    logic [7:0]            collected_letter;
    logic [WORD_LEN*8-1:0] secret_word;
    logic [WORD_LEN-1:0]   revealed;
    logic [3:0]            wrong_count;
    logic                  busy;
    logic                  guess_done;
    logic                  guess_hit;
    logic                  game_won;
    logic                  game_lost;

    modport master (
        output init, check_guess, collected_letter, secret_word,
        input  revealed, wrong_count, busy, guess_done, guess_hit, game_won, game_lost
    );

    modport slave (
        input  init, check_guess, collected_letter, secret_word,
        output revealed, wrong_count, busy, guess_done, guess_hit, game_won, game_lost
    );
endinterface

// File: rtl/hangman_guess_checker.sv
// Hangman guess checker: scans one secret-word slot per cycle per guess and tracks win/loss.
// Optional `GUESS_HISTORY_EN keeps a used-letter mask so repeated letters cost nothing.
module hangman_guess_checker #(
    parameter int unsigned WORD_LEN  = 8,
    parameter int unsigned MAX_WRONG = 6
) (
    input logic                    Clk,
    input logic                    Reset,
    hangman_guess_checker_if.slave bus
);
    localparam int unsigned IdxW = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;

    typedef enum logic [2:0] {StIdle, StScan, StUpdate, StWon, StLost} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [7:0]          letter_q, letter_d;
    logic                hit_q, hit_d;
    logic                chk_q;
    logic [WORD_LEN-1:0] revealed_q, revealed_d;
    logic [3:0]          wrong_q, wrong_d;

    logic                req;
    logic                letter_ok;
    logic                miss;
    logic [7:0]          slot;
    logic [WORD_LEN-1:0] unused;

`ifdef GUESS_HISTORY_EN
    logic [25:0] hist_q, hist_d;
    logic        rpt_q, rpt_d;
    logic [4:0]  lidx;

    assign lidx = 5'(bus.collected_letter - 8'h41);
`endif

    assign req       = bus.check_guess && !chk_q;
    assign letter_ok = (bus.collected_letter >= 8'h41) && (bus.collected_letter <= 8'h5A);

    always_comb begin
        slot   = 8'h00;
        unused = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            unused[i] = (bus.secret_word[i*8 +: 8] == 8'h00);
            if (idx_q == IdxW'(i)) slot = bus.secret_word[i*8 +: 8];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        letter_d   = letter_q;
        hit_d      = hit_q;
        revealed_d = revealed_q;
        wrong_d    = wrong_q;
`ifdef GUESS_HISTORY_EN
        hist_d     = hist_q;
        rpt_d      = rpt_q;
        miss       = !hit_q && !rpt_q;
`else
        miss       = !hit_q;
`endif

        if (bus.init) begin
            state_d    = StIdle;
            idx_d      = '0;
            hit_d      = 1'b0;
            wrong_d    = 4'd0;
            revealed_d = unused;
`ifdef GUESS_HISTORY_EN
            hist_d     = '0;
            rpt_d      = 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req && letter_ok) begin
                        letter_d = bus.collected_letter;
                        hit_d    = 1'b0;
                        idx_d    = '0;
`ifdef GUESS_HISTORY_EN
                        // A letter already tried goes straight to UPDATE as a no-penalty miss.
                        if (hist_q[lidx]) begin
                            rpt_d   = 1'b1;
                            state_d = StUpdate;
                        end else begin
                            rpt_d        = 1'b0;
                            hist_d[lidx] = 1'b1;
                            state_d      = StScan;
                        end
`else
                        state_d  = StScan;
`endif
                    end
                end
                StScan: begin
                    if (slot == letter_q) begin
                        revealed_d[idx_q] = 1'b1;
                        hit_d             = 1'b1;
                    end
                    if (idx_q == IdxW'(WORD_LEN - 1)) begin
                        state_d = StUpdate;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                StUpdate: begin
                    if (miss && (wrong_q < 4'(MAX_WRONG))) wrong_d = wrong_q + 4'd1;
                    if (&revealed_q) begin
                        state_d = StWon;
                    end else if (wrong_d == 4'(MAX_WRONG)) begin
                        state_d = StLost;
                    end else begin
                        state_d = StIdle;
                    end
                end
                StWon:   state_d = StWon;
                StLost:  state_d = StLost;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            letter_q   <= 8'h00;
            hit_q      <= 1'b0;
            chk_q      <= 1'b0;
            revealed_q <= '0;
            wrong_q    <= 4'd0;
`ifdef GUESS_HISTORY_EN
            hist_q     <= '0;
            rpt_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            letter_q   <= letter_d;
            hit_q      <= hit_d;
            chk_q      <= bus.check_guess;
            revealed_q <= revealed_d;
            wrong_q    <= wrong_d;
`ifdef GUESS_HISTORY_EN
            hist_q     <= hist_d;
            rpt_q      <= rpt_d;
`endif
        end
    end

    assign bus.revealed    = revealed_q;
    assign bus.wrong_count = wrong_q;
    assign bus.busy        = (state_q == StScan) || (state_q == StUpdate);
    assign bus.guess_done  = (state_q == StUpdate);
    assign bus.guess_hit   = (state_q == StUpdate) && hit_q;
    assign bus.game_won    = (state_q == StWon);
    assign bus.game_lost   = (state_q == StLost);
endmodule

// File: tb/tb_hangman_guess_checker.sv
// Self-checking bench for hangman_guess_checker: scoreboarded guesses plus reset/init/drop scenarios.
module tb_hangman_guess_checker;
    localparam int unsigned WL = 8;

    typedef struct {
        logic hit;
        int   lat;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset;
    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    logic [WL*8-1:0] cat_word;
    logic [WL-1:0]   exp_rev;

    hangman_guess_checker_if #(.WORD_LEN(WL)) bus ();

    hangman_guess_checker #(.WORD_LEN(WL), .MAX_WRONG(6)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [WL-1:0] model_unused(input logic [WL*8-1:0] w);
        logic [WL-1:0] r;
        for (int i = 0; i < WL; i++) r[i] = (w[i*8 +: 8] == 8'h00);
        return r;
    endfunction

    function automatic logic model_hit(input logic [WL*8-1:0] w, input logic [7:0] l);
        logic h = 1'b0;
        for (int i = 0; i < WL; i++) if (w[i*8 +: 8] == l) h = 1'b1;
        return h;
    endfunction

    function automatic logic [WL-1:0] model_rev(input logic [WL*8-1:0] w, input logic [7:0] l,
                                                input logic [WL-1:0] prev);
        logic [WL-1:0] r = prev;
        for (int i = 0; i < WL; i++) if (w[i*8 +: 8] == l) r[i] = 1'b1;
        return r;
    endfunction

    task automatic do_init(input logic [WL*8-1:0] w);
        @(negedge Clk);
        bus.secret_word = w;
        bus.init = 1'b1;
        @(negedge Clk);
        bus.init = 1'b0;
        exp_rev = model_unused(w);
    endtask

    // Raises one guess edge, then counts cycles until guess_done or the budget runs out.
    task automatic fire(input logic [7:0] l, input int budget, output int cycles, output bit got,
                        output logic hit, output bit busy_seen);
        @(negedge Clk);
        bus.collected_letter = l;
        bus.check_guess = 1'b1;
        cycles = 0;
        got = 1'b0;
        hit = 1'b0;
        busy_seen = 1'b0;
        while (cycles < budget) begin
            @(negedge Clk);
            cycles++;
            bus.check_guess = 1'b0;
            busy_seen |= bus.busy;
            if (bus.guess_done) begin
                got = 1'b1;
                hit = bus.guess_hit;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        n_total++;
        if ({bus.busy, bus.guess_done, bus.guess_hit, bus.game_won, bus.game_lost} !== 5'b0)
            $display("FAIL reset_status: got %b expected 00000",
                     {bus.busy, bus.guess_done, bus.guess_hit, bus.game_won, bus.game_lost});
        else n_pass++;
        n_total++;
        if (bus.revealed !== '0) $display("FAIL reset_revealed: got %b expected 0", bus.revealed);
        else n_pass++;
        n_total++;
        if (bus.wrong_count !== 4'd0) $display("FAIL reset_wrong: got %0d expected 0", bus.wrong_count);
        else n_pass++;
        Reset = 1'b0;
        do_init(cat_word);
        n_total++;
        if (bus.revealed !== 8'b11111000)
            $display("FAIL init_revealed: got %b expected 11111000", bus.revealed);
        else n_pass++;
    endtask

    task automatic test_guess_hit();
        int cyc; bit got; logic hit; bit bs; exp_t e;
        do_init(cat_word);
        sb.push_back('{hit: model_hit(cat_word, 8'h41), lat: WL + 1});
        exp_rev = model_rev(cat_word, 8'h41, exp_rev);
        fire(8'h41, 20, cyc, got, hit, bs);
        e = sb.pop_front();
        n_total++;
        if (!got || cyc !== e.lat) $display("FAIL hit_latency: got %0d (done=%0d) expected %0d", cyc, got, e.lat);
        else n_pass++;
        n_total++;
        if (hit !== e.hit) $display("FAIL hit_flag: got %b expected %b", hit, e.hit);
        else n_pass++;
        @(negedge Clk);
        n_total++;
        if (bus.revealed !== exp_rev || exp_rev !== 8'b11111010)
            $display("FAIL hit_revealed: got %b expected 11111010", bus.revealed);
        else n_pass++;
        n_total++;
        if (bus.wrong_count !== 4'd0) $display("FAIL hit_wrong: got %0d expected 0", bus.wrong_count);
        else n_pass++;
    endtask

    task automatic test_win();
        logic [7:0] seq [3] = '{8'h43, 8'h41, 8'h54};
        int cyc; bit got; logic hit; bit bs; exp_t e;
        do_init(cat_word);
        foreach (seq[k]) begin
            sb.push_back('{hit: model_hit(cat_word, seq[k]), lat: WL + 1});
            fire(seq[k], 20, cyc, got, hit, bs);
            e = sb.pop_front();
            n_total++;
            if (!got || cyc !== e.lat || hit !== e.hit)
                $display("FAIL win_guess%0d: got done=%0d lat=%0d hit=%b expected lat=%0d hit=%b",
                         k, got, cyc, hit, e.lat, e.hit);
            else n_pass++;
        end
        @(negedge Clk);
        n_total++;
        if ({bus.game_won, bus.game_lost, bus.revealed} !== {2'b10, 8'hFF})
            $display("FAIL win_state: got won=%b lost=%b rev=%b expected won=1 lost=0 rev=11111111",
                     bus.game_won, bus.game_lost, bus.revealed);
        else n_pass++;
        n_total++;
        if (bus.wrong_count !== 4'd0) $display("FAIL win_wrong: got %0d expected 0", bus.wrong_count);
        else n_pass++;
        fire(8'h42, 14, cyc, got, hit, bs);
        n_total++;
        if (got || !bus.game_won) $display("FAIL win_hold: got done=%0d won=%b expected done=0 won=1", got, bus.game_won);
        else n_pass++;
    endtask

    task automatic test_lose();
        logic [7:0] seq [6] = '{8'h42, 8'h44, 8'h45, 8'h46, 8'h47, 8'h48};
        int cyc; bit got; logic hit; bit bs; exp_t e;
        do_init(cat_word);
        foreach (seq[k]) begin
            sb.push_back('{hit: model_hit(cat_word, seq[k]), lat: WL + 1});
            fire(seq[k], 20, cyc, got, hit, bs);
            e = sb.pop_front();
            n_total++;
            if (!got || cyc !== e.lat || hit !== e.hit)
                $display("FAIL lose_guess%0d: got done=%0d lat=%0d hit=%b expected lat=%0d hit=%b",
                         k, got, cyc, hit, e.lat, e.hit);
            else n_pass++;
        end
        @(negedge Clk);
        n_total++;
        if (bus.wrong_count !== 4'd6 || bus.game_lost !== 1'b1)
            $display("FAIL lose_state: got wrong=%0d lost=%b expected wrong=6 lost=1",
                     bus.wrong_count, bus.game_lost);
        else n_pass++;
        fire(8'h49, 14, cyc, got, hit, bs);
        n_total++;
        if (got || bus.wrong_count !== 4'd6)
            $display("FAIL lose_seventh: got done=%0d wrong=%0d expected done=0 wrong=6", got, bus.wrong_count);
        else n_pass++;
    endtask

    task automatic test_repeat();
        int cyc; bit got; logic hit; bit bs; exp_t e;
        int exp_wrong;
        do_init(cat_word);
        sb.push_back('{hit: 1'b0, lat: WL + 1});
`ifdef GUESS_HISTORY_EN
        sb.push_back('{hit: 1'b0, lat: 1});
        exp_wrong = 1;
`else
        sb.push_back('{hit: 1'b0, lat: WL + 1});
        exp_wrong = 2;
`endif
        for (int k = 0; k < 2; k++) begin
            fire(8'h5A, 20, cyc, got, hit, bs);
            e = sb.pop_front();
            n_total++;
            if (!got || cyc !== e.lat || hit !== e.hit)
                $display("FAIL repeat_guess%0d: got done=%0d lat=%0d hit=%b expected lat=%0d hit=%b",
                         k, got, cyc, hit, e.lat, e.hit);
            else n_pass++;
        end
        @(negedge Clk);
        n_total++;
        if (bus.wrong_count !== 4'(exp_wrong))
            $display("FAIL repeat_wrong: got %0d expected %0d", bus.wrong_count, exp_wrong);
        else n_pass++;
    endtask

    task automatic test_drop();
        logic [7:0] bad [4] = '{8'h00, 8'h01, 8'h40, 8'h5B};
        int cyc; bit got; logic hit; bit bs; bit extra;
        do_init(cat_word);
        foreach (bad[k]) begin
            fire(bad[k], 12, cyc, got, hit, bs);
            n_total++;
            if (got || bs) $display("FAIL invalid_%0d: got done=%0d busy=%0d expected 0 0", k, got, bs);
            else n_pass++;
        end
        // Second edge ('C') arrives mid-scan and must vanish.
        @(negedge Clk);
        bus.collected_letter = 8'h41;
        bus.check_guess = 1'b1;
        cyc = 0; got = 1'b0;
        while (cyc < 20 && !got) begin
            @(negedge Clk);
            cyc++;
            bus.check_guess = (cyc == 3);
            if (cyc == 3) bus.collected_letter = 8'h43;
            got = bus.guess_done;
        end
        n_total++;
        if (!got || cyc !== WL + 1) $display("FAIL drop_first: got done=%0d lat=%0d expected lat=%0d", got, cyc, WL + 1);
        else n_pass++;
        extra = 1'b0;
        repeat (14) begin
            @(negedge Clk);
            extra |= bus.guess_done | bus.busy;
        end
        n_total++;
        if (extra || bus.revealed !== 8'b11111010)
            $display("FAIL drop_busy_edge: got extra=%0d rev=%b expected extra=0 rev=11111010", extra, bus.revealed);
        else n_pass++;
    endtask

    task automatic test_abort();
        bit extra;
        do_init(cat_word);
        @(negedge Clk);
        bus.collected_letter = 8'h41;
        bus.check_guess = 1'b1;
        @(negedge Clk);
        bus.check_guess = 1'b0;
        repeat (2) @(negedge Clk);
        bus.init = 1'b1;
        @(negedge Clk);
        bus.init = 1'b0;
        extra = 1'b0;
        repeat (12) begin
            @(negedge Clk);
            extra |= bus.guess_done | bus.busy;
        end
        n_total++;
        if (extra || bus.revealed !== 8'b11111000)
            $display("FAIL init_abort: got extra=%0d rev=%b expected extra=0 rev=11111000", extra, bus.revealed);
        else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        bit extra;
        do_init(cat_word);
        @(negedge Clk);
        bus.collected_letter = 8'h41;
        bus.check_guess = 1'b1;
        @(negedge Clk);
        bus.check_guess = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        #1;
        n_total++;
        if ({bus.revealed, bus.wrong_count, bus.busy, bus.guess_done, bus.guess_hit,
             bus.game_won, bus.game_lost} !== '0)
            $display("FAIL reset_async: got rev=%b wrong=%0d busy=%b done=%b expected all 0",
                     bus.revealed, bus.wrong_count, bus.busy, bus.guess_done);
        else n_pass++;
        @(negedge Clk);
        Reset = 1'b0;
        extra = 1'b0;
        repeat (12) begin
            @(negedge Clk);
            extra |= bus.guess_done | bus.busy;
        end
        n_total++;
        if (extra) $display("FAIL reset_discard: got activity=%0d expected 0", extra);
        else n_pass++;
        do_init(cat_word);
        n_total++;
        if (bus.revealed !== 8'b11111000)
            $display("FAIL reset_reinit: got %b expected 11111000", bus.revealed);
        else n_pass++;
    endtask

    task automatic test_empty_word();
        int cyc; bit got; logic hit; bit bs; exp_t e;
        do_init('0);
        sb.push_back('{hit: 1'b0, lat: WL + 1});
        fire(8'h51, 20, cyc, got, hit, bs);
        e = sb.pop_front();
        n_total++;
        if (!got || cyc !== e.lat || hit !== e.hit)
            $display("FAIL empty_guess: got done=%0d lat=%0d hit=%b expected lat=%0d hit=%b",
                     got, cyc, hit, e.lat, e.hit);
        else n_pass++;
        @(negedge Clk);
        n_total++;
        if (bus.game_won !== 1'b1) $display("FAIL empty_won: got %b expected 1", bus.game_won);
        else n_pass++;
    endtask

    initial begin
        cat_word = '0;
        cat_word[7:0]   = 8'h43;
        cat_word[15:8]  = 8'h41;
        cat_word[23:16] = 8'h54;
        Reset = 1'b1;
        bus.init = 1'b0;
        bus.check_guess = 1'b0;
        bus.collected_letter = 8'h00;
        bus.secret_word = '0;
        test_reset();
        test_guess_hit();
        test_win();
        test_lose();
        test_repeat();
        test_drop();
        test_abort();
        test_reset_mid_scan();
        test_empty_word();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
